// File: rtl/id_stage_pipe_pkg.sv
// Shared decode definitions for the ID stage: RV32I opcode/funct constants,
// the op encoding presented to EX, and the instruction decode helper.
package id_stage_pipe_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [OP_W-1:0] {
        OP_NON, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
    } op_e;

    // Source of the branch/jump base address
    typedef enum logic [1:0] {BR_NONE, BR_PC, BR_RS1} br_sel_e;

    typedef struct packed {
        op_e         op;
        logic [4:0]  rd;
        logic        rs1_use;
        logic        rs2_use;
        logic        wb_en;
        logic        illegal;
        br_sel_e     br_sel;
        logic [31:0] imm;      // 32-bit sign-extended; widened to XLEN by the stage
    } dec_t;

    // Pure decode of one instruction word; illegal encodings clear every field
    function automatic dec_t decode_inst(input logic [INST_W-1:0] inst);
        dec_t       d;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       has_rd;
        logic       bad;
        d      = '0;
        d.op   = OP_NON;
        f3     = inst[14:12];
        f7     = inst[31:25];
        has_rd = 1'b0;
        bad    = 1'b0;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                d.op   = (inst[6:0] == OPC_LUI) ? OP_LUI : OP_AUIPC;
                d.imm  = {inst[31:12], 12'b0};
                has_rd = 1'b1;
            end
            OPC_JAL: begin
                d.op     = OP_JAL;
                d.imm    = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                d.br_sel = BR_PC;
                has_rd   = 1'b1;
            end
            OPC_JALR: begin
                d.op      = OP_JALR;
                d.imm     = {{20{inst[31]}}, inst[31:20]};
                d.rs1_use = 1'b1;
                d.br_sel  = BR_RS1;
                has_rd    = 1'b1;
                bad       = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                case (f3)
                    3'b000:  d.op = OP_BEQ;
                    3'b001:  d.op = OP_BNE;
                    3'b100:  d.op = OP_BLT;
                    3'b101:  d.op = OP_BGE;
                    3'b110:  d.op = OP_BLTU;
                    3'b111:  d.op = OP_BGEU;
                    default: bad  = 1'b1;
                endcase
                d.imm     = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                d.rs1_use = 1'b1;
                d.rs2_use = 1'b1;
                d.br_sel  = BR_PC;
            end
            OPC_LOAD: begin
                case (f3)
                    3'b000:  d.op = OP_LB;
                    3'b001:  d.op = OP_LH;
                    3'b010:  d.op = OP_LW;
                    3'b100:  d.op = OP_LBU;
                    3'b101:  d.op = OP_LHU;
                    default: bad  = 1'b1;
                endcase
                d.imm     = {{20{inst[31]}}, inst[31:20]};
                d.rs1_use = 1'b1;
                has_rd    = 1'b1;
            end
            OPC_STORE: begin
                case (f3)
                    3'b000:  d.op = OP_SB;
                    3'b001:  d.op = OP_SH;
                    3'b010:  d.op = OP_SW;
                    default: bad  = 1'b1;
                endcase
                d.imm     = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                d.rs1_use = 1'b1;
                d.rs2_use = 1'b1;
            end
            OPC_OPIMM: begin
                d.imm = {{20{inst[31]}}, inst[31:20]};
                case (f3)
                    3'b000: d.op = OP_ADDI;
                    3'b010: d.op = OP_SLTI;
                    3'b011: d.op = OP_SLTIU;
                    3'b100: d.op = OP_XORI;
                    3'b110: d.op = OP_ORI;
                    3'b111: d.op = OP_ANDI;
                    3'b001: begin
                        d.op  = OP_SLLI;
                        d.imm = {27'b0, inst[24:20]};
                        bad   = (f7 != F7_BASE);
                    end
                    default: begin
                        d.op  = (f7 == F7_ALT) ? OP_SRAI : OP_SRLI;
                        d.imm = {27'b0, inst[24:20]};
                        bad   = (f7 != F7_BASE) && (f7 != F7_ALT);
                    end
                endcase
                d.rs1_use = 1'b1;
                has_rd    = 1'b1;
            end
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  d.op = OP_ADD;
                        3'b001:  d.op = OP_SLL;
                        3'b010:  d.op = OP_SLT;
                        3'b011:  d.op = OP_SLTU;
                        3'b100:  d.op = OP_XOR;
                        3'b101:  d.op = OP_SRL;
                        3'b110:  d.op = OP_OR;
                        default: d.op = OP_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    d.op = OP_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    d.op = OP_SRA;
                end else begin
                    bad = 1'b1;
                end
                d.rs1_use = 1'b1;
                d.rs2_use = 1'b1;
                has_rd    = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            d         = '0;
            d.op      = OP_NON;
            d.br_sel  = BR_NONE;
            d.illegal = 1'b1;
        end else begin
            d.rd    = has_rd ? inst[11:7] : 5'd0;
            d.wb_en = has_rd && (inst[11:7] != 5'd0);
        end
        return d;
    endfunction

endpackage

// File: rtl/id_stage_pipe_operand_sel.sv
// Operand resolve for one source register.
//   addr/use    : register index and whether the instruction reads it
//   rf_data     : regfile value for addr
//   fwd_*       : forwarding channels, index 0 youngest and highest priority
//   value_c     : resolved operand (0 for x0 or unused)
//   hazard_c    : winning channel still has its result in flight
module id_operand_sel
    import id_stage_pipe_pkg::*;
#(
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned XLEN    = 32
) (
    input  logic [REG_AW-1:0]         addr,
    input  logic                      use_rs,
    input  logic [XLEN-1:0]           rf_data,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_pending,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    output logic [XLEN-1:0]           value_c,
    output logic                      hazard_c
);

    // First matching channel in ascending order wins
    always_comb begin
        logic found;
        value_c  = rf_data;
        hazard_c = 1'b0;
        found    = 1'b0;
        for (int unsigned k = 0; k < NUM_FWD; k++) begin
            if (!found && fwd_valid[k] && fwd_addr[REG_AW*k +: REG_AW] == addr) begin
                found    = 1'b1;
                value_c  = fwd_data[XLEN*k +: XLEN];
                hazard_c = fwd_pending[k];
            end
        end
        if (!use_rs || addr == '0) begin
            value_c  = '0;
            hazard_c = 1'b0;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// RV32I decode stage with forwarding, load-use stall, flush and a registered
// valid/ready ID/EX payload.
//   in_valid/in_ready, pc_in, inst_in : IF side handshake
//   rs*_addr / rs*_data               : same-cycle regfile read
//   fwd_*                             : NUM_FWD forwarding channels
//   out_*                             : registered ID/EX payload, out_valid/out_ready
//   flush                             : kill held payload and current input
//   stall_cnt / stall_clr             : saturating hazard-cycle counter
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned AW          = 32,
    parameter int unsigned NUM_FWD     = 2,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AW-1:0]             pc_in,
    input  logic [INST_W-1:0]         inst_in,
    input  logic                      flush,
    output logic [REG_AW-1:0]         rs1_addr,
    output logic [REG_AW-1:0]         rs2_addr,
    input  logic [XLEN-1:0]           rs1_data,
    input  logic [XLEN-1:0]           rs2_data,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_pending,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [AW-1:0]             out_pc,
    output logic [OP_W-1:0]           out_op,
    output logic [REG_AW-1:0]         out_rd,
    output logic [XLEN-1:0]           out_rs1_val,
    output logic [XLEN-1:0]           out_rs2_val,
    output logic [XLEN-1:0]           out_imm,
    output logic                      out_wb_en,
    output logic [XLEN-1:0]           out_br_base,
    output logic [XLEN-1:0]           out_br_off,
    output logic                      out_illegal,
    output logic [STALL_CNT_W-1:0]    stall_cnt,
    input  logic                      stall_clr
);

    dec_t            dec;
    logic [XLEN-1:0] rs1_val_c, rs2_val_c, imm_x_c, br_base_c, br_off_c;
    logic            rs1_haz_c, rs2_haz_c, hazard_c, accept_c;

    always_comb dec = decode_inst(inst_in);

    assign rs1_addr = inst_in[19:15];
    assign rs2_addr = inst_in[24:20];

    id_operand_sel #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_rs1_sel (
        .addr(rs1_addr), .use_rs(dec.rs1_use), .rf_data(rs1_data),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .value_c(rs1_val_c), .hazard_c(rs1_haz_c)
    );

    id_operand_sel #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_rs2_sel (
        .addr(rs2_addr), .use_rs(dec.rs2_use), .rf_data(rs2_data),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .value_c(rs2_val_c), .hazard_c(rs2_haz_c)
    );

    assign imm_x_c  = XLEN'($signed(dec.imm));
    assign hazard_c = in_valid && (rs1_haz_c || rs2_haz_c);
    assign in_ready = !hazard_c && !flush && (!out_valid || out_ready);
    assign accept_c = in_valid && in_ready;

    // Branch target operands: PC-relative for JAL/branches, register-relative for JALR
    always_comb begin
        br_base_c = '0;
        br_off_c  = '0;
        case (dec.br_sel)
            BR_PC: begin
                br_base_c = XLEN'(pc_in);
                br_off_c  = imm_x_c;
            end
            BR_RS1: begin
                br_base_c = rs1_val_c;
                br_off_c  = imm_x_c;
            end
            default: ;
        endcase
    end

    // Valid flag: flush dominates, then capture, then drain
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept_c) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload only changes on capture, so it is stable while EX back-pressures
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_pc      <= '0;
            out_op      <= OP_NON;
            out_rd      <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_imm     <= '0;
            out_wb_en   <= 1'b0;
            out_br_base <= '0;
            out_br_off  <= '0;
            out_illegal <= 1'b0;
        end else if (accept_c) begin
            out_pc      <= pc_in;
            out_op      <= dec.op;
            out_rd      <= dec.rd;
            out_rs1_val <= rs1_val_c;
            out_rs2_val <= rs2_val_c;
            out_imm     <= imm_x_c;
            out_wb_en   <= dec.wb_en;
            out_br_base <= br_base_c;
            out_br_off  <= br_off_c;
            out_illegal <= dec.illegal;
        end
    end

    // Hazard-cycle counter; a flushed cycle is not a stall
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (hazard_c && !flush && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomized bench for id_stage_pipe against a table-driven decode model.
module tb_id_stage_pipe;
    import id_stage_pipe_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 32;
    localparam int unsigned NF   = 2;
    localparam int unsigned SCW  = 3;
    localparam int unsigned NT   = 37;
    localparam int F_U = 0, F_J = 1, F_I = 2, F_B = 3, F_S = 4, F_SH = 5, F_R = 6;

    // RV32I mask/match templates
    localparam logic [31:0] T_MASK [NT] = '{
        32'h7F, 32'h7F, 32'h7F, 32'h707F,
        32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F,
        32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F,
        32'h707F, 32'h707F, 32'h707F,
        32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F, 32'h707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F};
    localparam logic [31:0] T_MATCH [NT] = '{
        32'h37, 32'h17, 32'h6F, 32'h67,
        32'h63, 32'h1063, 32'h4063, 32'h5063, 32'h6063, 32'h7063,
        32'h03, 32'h1003, 32'h2003, 32'h4003, 32'h5003,
        32'h23, 32'h1023, 32'h2023,
        32'h13, 32'h2013, 32'h3013, 32'h4013, 32'h6013, 32'h7013,
        32'h1013, 32'h5013, 32'h40005013,
        32'h33, 32'h40000033, 32'h1033, 32'h2033, 32'h3033,
        32'h4033, 32'h5033, 32'h40005033, 32'h6033, 32'h7033};
    localparam logic [5:0] T_OP [NT] = '{
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND};
    localparam int T_FMT [NT] = '{
        F_U, F_U, F_J, F_I,
        F_B, F_B, F_B, F_B, F_B, F_B,
        F_I, F_I, F_I, F_I, F_I,
        F_S, F_S, F_S,
        F_I, F_I, F_I, F_I, F_I, F_I,
        F_SH, F_SH, F_SH,
        F_R, F_R, F_R, F_R, F_R, F_R, F_R, F_R, F_R, F_R};

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [AW-1:0]     pc_in, out_pc;
    logic [31:0]       inst_in;
    logic [4:0]        rs1_addr, rs2_addr, out_rd;
    logic [XLEN-1:0]   rs1_data, rs2_data, out_rs1_val, out_rs2_val, out_imm, out_br_base, out_br_off;
    logic [NF-1:0]     fwd_valid, fwd_pending;
    logic [NF*5-1:0]   fwd_addr;
    logic [NF*XLEN-1:0] fwd_data;
    logic [5:0]        out_op;
    logic              out_wb_en, out_illegal, stall_clr;
    logic [SCW-1:0]    stall_cnt;

    // Expected state of the stage
    logic            m_valid = 1'b0, m_wb = 1'b0, m_ill = 1'b0;
    logic [AW-1:0]   m_pc = '0;
    logic [5:0]      m_op = OP_NON;
    logic [4:0]      m_rd = '0;
    logic [XLEN-1:0] m_rs1 = '0, m_rs2 = '0, m_imm = '0, m_bb = '0, m_bo = '0;
    logic [SCW-1:0]  m_cnt = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(XLEN), .AW(AW), .NUM_FWD(NF), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .inst_in(inst_in), .flush(flush),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
        .out_rd(out_rd), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_imm(out_imm), .out_wb_en(out_wb_en), .out_br_base(out_br_base),
        .out_br_off(out_br_off), .out_illegal(out_illegal),
        .stall_cnt(stall_cnt), .stall_clr(stall_clr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic ref_decode(input logic [31:0] i, output logic ok, output logic [5:0] op,
                              output int fmt);
        ok = 1'b0; op = OP_NON; fmt = -1;
        for (int t = 0; t < NT; t++) begin
            if (!ok && (i & T_MASK[t]) == T_MATCH[t]) begin
                ok = 1'b1; op = T_OP[t]; fmt = T_FMT[t];
            end
        end
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] i, input int fmt);
        logic signed [31:0] s;
        s = $signed(i);
        case (fmt)
            F_U:  return i & 32'hFFFFF000;
            F_J:  return (32'(s >>> 11) & 32'hFFF00000) | (32'(i[19:12]) << 12)
                       | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            F_I:  return 32'(s >>> 20);
            F_B:  return (32'(s >>> 19) & 32'hFFFFF000) | (32'(i[7]) << 11)
                       | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            F_S:  return (32'(s >>> 20) & 32'hFFFFFFE0) | 32'(i[11:7]);
            F_SH: return 32'(i[24:20]);
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_opnd(input logic [4:0] a, input logic used, input logic [XLEN-1:0] rf,
                            output logic [XLEN-1:0] v, output logic hz);
        logic hit;
        hz = 1'b0; v = rf; hit = 1'b0;
        if (!used || a == 5'd0) begin
            v = '0;
        end else begin
            for (int k = 0; k < NF; k++) begin
                if (!hit && fwd_valid[k] && fwd_addr[5*k +: 5] == a) begin
                    hit = 1'b1; v = fwd_data[XLEN*k +: XLEN]; hz = fwd_pending[k];
                end
            end
        end
    endtask

    task automatic compare_all();
        check("out_valid",   out_valid,   m_valid);
        check("out_pc",      out_pc,      m_pc);
        check("out_op",      out_op,      m_op);
        check("out_rd",      out_rd,      m_rd);
        check("out_rs1_val", out_rs1_val, m_rs1);
        check("out_rs2_val", out_rs2_val, m_rs2);
        check("out_imm",     out_imm,     m_imm);
        check("out_wb_en",   out_wb_en,   m_wb);
        check("out_br_base", out_br_base, m_bb);
        check("out_br_off",  out_br_off,  m_bo);
        check("out_illegal", out_illegal, m_ill);
        check("stall_cnt",   stall_cnt,   m_cnt);
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs
    task automatic step();
        logic ok, urd, u1, u2, h1, h2, hz, rdy;
        logic [5:0] op;
        int fmt;
        logic [XLEN-1:0] v1, v2;
        logic [31:0] imm;
        #1;
        ref_decode(inst_in, ok, op, fmt);
        urd = ok && (fmt == F_U || fmt == F_J || fmt == F_I || fmt == F_SH || fmt == F_R);
        u1  = ok && (fmt == F_I || fmt == F_SH || fmt == F_B || fmt == F_S || fmt == F_R);
        u2  = ok && (fmt == F_B || fmt == F_S || fmt == F_R);
        ref_opnd(inst_in[19:15], u1, rs1_data, v1, h1);
        ref_opnd(inst_in[24:20], u2, rs2_data, v2, h2);
        hz  = in_valid && (h1 || h2);
        rdy = !hz && !flush && (!m_valid || out_ready);
        check("in_ready", in_ready, rdy);
        check("rs_addr", {rs1_addr, rs2_addr}, {inst_in[19:15], inst_in[24:20]});
        imm = ok ? ref_imm(inst_in, fmt) : 32'd0;
        @(posedge clk);
        if (!rst) begin
            m_valid = 0; m_pc = '0; m_op = OP_NON; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
            m_imm = '0; m_wb = 0; m_bb = '0; m_bo = '0; m_ill = 0; m_cnt = '0;
        end else begin
            if (stall_clr) m_cnt = '0;
            else if (hz && !flush && m_cnt != {SCW{1'b1}}) m_cnt = m_cnt + 1'b1;
            if (flush) begin
                m_valid = 0;
            end else if (in_valid && rdy) begin
                m_valid = 1;
                m_pc  = pc_in;
                m_op  = ok ? op : OP_NON;
                m_ill = !ok;
                m_rd  = urd ? inst_in[11:7] : 5'd0;
                m_wb  = urd && inst_in[11:7] != 5'd0;
                m_rs1 = v1;
                m_rs2 = v2;
                m_imm = imm;
                m_bb  = '0;
                m_bo  = '0;
                if (ok && (fmt == F_J || fmt == F_B)) begin
                    m_bb = pc_in; m_bo = imm;
                end else if (ok && op == OP_JALR) begin
                    m_bb = v1; m_bo = imm;
                end
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
        #1;
        compare_all();
    endtask

    task automatic rand_inputs();
        logic [31:0] t;
        int r, idx;
        r = $urandom_range(0, 9);
        if (r < 8) begin
            idx = $urandom_range(0, NT - 1);
            t = $urandom;
            t[24:20] = 5'($urandom_range(0, 7));
            t[19:15] = 5'($urandom_range(0, 7));
            inst_in = (t & ~T_MASK[idx]) | T_MATCH[idx];
        end else if (r == 8) begin
            inst_in = $urandom;
        end else begin
            inst_in = 32'hFFFFFFFF;
        end
        in_valid = $urandom_range(0, 9) < 8;
        pc_in    = $urandom & ~32'd3;
        rs1_data = $urandom;
        rs2_data = $urandom;
        for (int k = 0; k < NF; k++) begin
            fwd_valid[k]   = 1'($urandom_range(0, 1));
            fwd_pending[k] = $urandom_range(0, 4) == 0;
            fwd_addr[5*k +: 5] = 5'($urandom_range(0, 7));
            fwd_data[XLEN*k +: XLEN] = $urandom;
        end
        out_ready = $urandom_range(0, 9) < 7;
        flush     = $urandom_range(0, 19) == 0;
        stall_clr = $urandom_range(0, 19) == 0;
        rst       = $urandom_range(0, 49) != 0;
    endtask

    initial begin
        rst = 0; in_valid = 0; pc_in = '0; inst_in = '0; flush = 0;
        rs1_data = '0; rs2_data = '0; fwd_valid = '0; fwd_pending = '0;
        fwd_addr = '0; fwd_data = '0; out_ready = 0; stall_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1;

        // ADDI x5,x0,7
        in_valid = 1; out_ready = 1; pc_in = 32'h100; inst_in = 32'h00700293;
        step();
        check("t1_op", out_op, OP_ADDI);
        check("t1_imm", out_imm, 32'd7);

        // ADD x3,x1,x2 with both channels matching x1: channel 0 wins
        inst_in = 32'h002081B3; pc_in = 32'h104;
        fwd_valid = 2'b11; fwd_addr = {5'd1, 5'd1}; fwd_data = {32'hBB, 32'hAA}; rs2_data = 32'd5;
        step();
        check("t2_rs1", out_rs1_val, 32'hAA);
        check("t2_rs2", out_rs2_val, 32'd5);

        // Load-use: youngest channel still pending
        fwd_pending = 2'b01; pc_in = 32'h108;
        repeat (3) step();
        check("t3_stall", stall_cnt, 3'd3);
        fwd_pending = 2'b00;
        step();
        check("t3_accept", out_valid, 1'b1);

        // Back-pressure then release
        out_ready = 0; inst_in = 32'h00700293; pc_in = 32'h10C;
        repeat (2) step();
        check("t4_hold", out_rs1_val, 32'hAA);
        out_ready = 1;
        repeat (2) step();

        // Flush with payload held and input offered
        flush = 1; pc_in = 32'h110;
        step();
        check("t5_flush", out_valid, 1'b0);
        check("t5_cnt", stall_cnt, 3'd3);
        flush = 0;

        // All-ones word is undecodable, then mid-stream reset
        inst_in = 32'hFFFFFFFF;
        step();
        check("t6_ill", out_illegal, 1'b1);
        check("t6_op", out_op, OP_NON);
        inst_in = 32'h00700293;
        rst = 0;
        step();
        check("t6_rst", out_valid, 1'b0);
        rst = 1;

        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
